// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The master drives the operands and out_ready; the slave (the adder) drives the results.
interface pipelined_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bin;
  logic             cin;
  logic             sub;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output ain, bin, cin, sub, in_valid, out_ready,
    input  in_ready, sum, cout, ovf, out_valid
  );

  modport slave (
    input  ain, bin, cin, sub, in_valid, out_ready,
    output in_ready, sum, cout, ovf, out_valid
  );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor. Each of the STAGES stages ripples one CW-bit chunk
// through full-adder cells and registers the carry for the next stage. B is inverted on entry
// for subtraction, so later stages only see A, B' and the carry. WIDTH must be a multiple of
// STAGES. The whole pipeline stalls together when the output is held.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input logic              clk,
  input logic              rst,
  pipelined_adder_if.slave io
);

  localparam int unsigned CW = WIDTH / STAGES;

  logic advance;

  // Stage k inputs: stage 0 from the port, stage k>0 from the register of stage k-1.
  logic [WIDTH-1:0]  a_in [STAGES];
  logic [WIDTH-1:0]  b_in [STAGES];
  logic [WIDTH-1:0]  s_in [STAGES];
  logic [STAGES-1:0] c_in;
  logic [STAGES-1:0] v_in;

  // Stage k combinational results.
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [STAGES-1:0] c_d;
  logic              ovf_d;
  logic              carry;

  // Stage registers; the last entry is the output register.
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;
  logic              ovf_q;

  assign advance = ~v_q[STAGES-1] | io.out_ready;

  // Route operands into stage 0 and the skewed register contents into the later stages.
  always_comb begin
    c_in    = '0;
    v_in    = '0;
    a_in[0] = io.ain;
    b_in[0] = io.sub ? ~io.bin : io.bin;
    s_in[0] = '0;
    c_in[0] = io.sub | io.cin;
    v_in[0] = io.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = v_q[k-1];
    end
  end

  // Ripple each stage's chunk; lower sum chunks pass through untouched.
  always_comb begin
    c_d   = '0;
    carry = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      s_d[k] = s_in[k];
      carry  = c_in[k];
      for (int i = 0; i < CW; i++) begin
        s_d[k][k*CW+i] = a_in[k][k*CW+i] ^ b_in[k][k*CW+i] ^ carry;
        carry = (a_in[k][k*CW+i] & b_in[k][k*CW+i]) |
                (carry & (a_in[k][k*CW+i] ^ b_in[k][k*CW+i]));
      end
      c_d[k] = carry;
    end
    // Signed overflow: operands agree in sign but the result does not.
    ovf_d = (a_in[STAGES-1][WIDTH-1] == b_in[STAGES-1][WIDTH-1]) &
            (s_d[STAGES-1][WIDTH-1] != a_in[STAGES-1][WIDTH-1]);
  end

  // Advance every stage together, or hold all of them when the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (advance) begin
      v_q   <= v_in;
      c_q   <= c_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  assign io.in_ready  = advance;
  assign io.sum       = s_q[STAGES-1];
  assign io.cout      = c_q[STAGES-1];
  assign io.ovf       = ovf_q;
  assign io.out_valid = v_q[STAGES-1];

endmodule
